// File: rtl/instr_fetch_if.sv
// Instruction ROM bus between the fetch stage (master) and the combinational ROM (slave).
interface instr_fetch_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;

    modport master (
        output imem_addr,
        input  imem_instr
    );

    modport slave (
        input  imem_addr,
        output imem_instr
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and saturating fetch counter.
// Optional PC bounds/alignment fault enabled by defining FETCH_BOUNDS_CHECK_EN.
module instr_fetch #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_if.master        imem,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 redirect_valid,
    input  logic [63:0]          redirect_target,
    output logic [63:0]          if_pc,
    output logic [31:0]          if_instr,
    output logic                 if_valid,
    output logic [31:0]          fetch_count,
    output logic                 fault
);

    if (MEM_SIZE <= 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_mem_size
        $error("instr_fetch: MEM_SIZE must be a power of two greater than 4");
    end

    logic [63:0] pc_q, pc_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        halted;
    logic        pc_load;

`ifdef FETCH_BOUNDS_CHECK_EN
    // Last byte address at which a full 32-bit word still fits in the ROM.
    localparam logic [63:0] LAST_WORD_ADDR = 64'(MEM_SIZE) - 64'd4;

    logic fault_q, fault_d;
    logic pc_bad;

    assign halted = fault_q;
    assign pc_bad = (pc_d[1:0] != 2'b00) || (pc_d > LAST_WORD_ADDR);

    always_comb begin
        fault_d = fault_q;
        if (!fault_q && pc_load && pc_bad) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign halted = 1'b0;
    assign fault  = 1'b0;
`endif

    // A redirect always loads the PC, even under stall, so it can never be lost.
    always_comb begin
        pc_d          = pc_q;
        pc_load       = 1'b0;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;

        if (halted) begin
            if_valid_d = 1'b0;
        end else begin
            if (redirect_valid) begin
                pc_d    = redirect_target;
                pc_load = 1'b1;
            end else if (!stall) begin
                pc_d    = pc_q + 64'd4;
                pc_load = 1'b1;
            end

            if (redirect_valid || flush) begin
                if_valid_d = 1'b0;
            end else if (!stall) begin
                if_pc_d    = pc_q;
                if_instr_d = imem.imem_instr;
                if_valid_d = 1'b1;
                if (fetch_count_q != '1) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            if_pc_q       <= '0;
            if_instr_q    <= '0;
            if_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign if_valid       = if_valid_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: behavioural model compared every cycle plus directed literal checks.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [31:0] fetch_count;
    logic        fault;

    int tests = 0;
    int fails = 0;

    instr_fetch_if imem_bus();

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return {8'hD5, a[25:2]};
    endfunction

    assign imem_bus.imem_instr = rom_word(imem_bus.imem_addr);

    instr_fetch #(.MEM_SIZE(1024), .RESET_PC(64'd0)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem            (imem_bus),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_valid        (if_valid),
        .fetch_count     (fetch_count),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic        m_on = 1'b0;
    logic [63:0] m_pc;
    logic [63:0] m_if_pc;
    logic [31:0] m_if_instr;
    logic        m_if_valid;
    logic [31:0] m_count;
    logic        m_fault;
    logic [63:0] m_pc_next;
    logic        m_pc_moves;
    logic        m_capture;

    function automatic bit out_of_bounds(input logic [63:0] a);
        return (a % 4 != 0) || (a + 3 >= 1024);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_on       = 1'b1;
            m_pc       = 64'd0;
            m_if_pc    = 64'd0;
            m_if_instr = 32'd0;
            m_if_valid = 1'b0;
            m_count    = 32'd0;
            m_fault    = 1'b0;
        end else if (m_on) begin
            m_pc_moves = !m_fault && (redirect_valid || !stall);
            m_capture  = !m_fault && !redirect_valid && !flush && !stall;
            m_pc_next  = !m_pc_moves ? m_pc : (redirect_valid ? redirect_target : m_pc + 64'd4);
            if (m_capture) begin
                m_if_pc    = m_pc;
                m_if_instr = rom_word(m_pc);
                m_if_valid = 1'b1;
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            end else if (!stall || redirect_valid || flush || m_fault) begin
                m_if_valid = 1'b0;
            end
`ifdef FETCH_BOUNDS_CHECK_EN
            if (m_pc_moves && out_of_bounds(m_pc_next)) m_fault = 1'b1;
`endif
            m_pc = m_pc_next;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("mdl_imem_addr",   imem_bus.imem_addr, m_pc);
            check("mdl_if_pc",       if_pc, m_if_pc);
            check("mdl_if_instr",    64'(if_instr), 64'(m_if_instr));
            check("mdl_if_valid",    64'(if_valid), 64'(m_if_valid));
            check("mdl_fetch_count", 64'(fetch_count), 64'(m_count));
            check("mdl_fault",       64'(fault), 64'(m_fault));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [63:0] pc, input logic [63:0] ipc,
                                input logic v, input logic [31:0] cnt);
        check({name, "_pc"},    imem_bus.imem_addr, pc);
        check({name, "_if_pc"}, if_pc, ipc);
        check({name, "_valid"}, 64'(if_valid), 64'(v));
        check({name, "_count"}, 64'(fetch_count), 64'(cnt));
    endtask

    task automatic set_in(input logic s, input logic f, input logic r, input logic [63:0] t);
        stall = s;
        flush = f;
        redirect_valid = r;
        redirect_target = t;
    endtask

    typedef struct {
        logic        s;
        logic        f;
        logic        r;
        logic [63:0] t;
    } vec_t;

    vec_t vecs[12];

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 64'd0);
        tick();
        check("rst_pc",       imem_bus.imem_addr, 64'd0);
        check("rst_if_pc",    if_pc, 64'd0);
        check("rst_if_instr", 64'(if_instr), 64'd0);
        check("rst_valid",    64'(if_valid), 64'd0);
        check("rst_count",    64'(fetch_count), 64'd0);
        check("rst_fault",    64'(fault), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            expect_state("free", 64'(4 * i), (i < 2) ? 64'd0 : 64'(4 * (i - 1)), i != 0, 32'(i));
        end
        check("free_instr", 64'(if_instr), 64'(32'hD500_0002));

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        expect_state("pre_stall", 64'd8, 64'd4, 1'b1, 32'd2);
        set_in(1, 0, 0, 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_state("stall", 64'd8, 64'd4, 1'b1, 32'd2);
        end
        set_in(0, 0, 0, 64'd0);
        tick();
        expect_state("unstall", 64'd12, 64'd8, 1'b1, 32'd3);
        tick();
        expect_state("pre_redir", 64'd16, 64'd12, 1'b1, 32'd4);

        set_in(1, 0, 1, 64'h40);
        tick();
        expect_state("redir_n1", 64'h40, 64'd12, 1'b0, 32'd4);
        set_in(0, 0, 0, 64'd0);
        tick();
        expect_state("redir_n2", 64'h44, 64'h40, 1'b1, 32'd5);

        set_in(0, 0, 1, 64'h14);
        tick();
        expect_state("to20", 64'h14, 64'h40, 1'b0, 32'd5);
        set_in(0, 1, 0, 64'd0);
        tick();
        expect_state("flush", 64'h18, 64'h40, 1'b0, 32'd5);
        set_in(0, 0, 0, 64'd0);
        tick();
        expect_state("post_flush", 64'h1C, 64'h18, 1'b1, 32'd6);

        set_in(1, 1, 0, 64'd0);
        tick();
        expect_state("flush_stall", 64'h1C, 64'h18, 1'b0, 32'd6);
        set_in(0, 0, 0, 64'd0);
        tick();
        expect_state("post_fs", 64'h20, 64'h1C, 1'b1, 32'd7);

        reset = 1'b1;
        set_in(0, 0, 1, 64'h80);
        tick();
        expect_state("mid_rst", 64'd0, 64'd0, 1'b0, 32'd0);
        check("mid_rst_instr", 64'(if_instr), 64'd0);
        reset = 1'b0;
        set_in(0, 0, 0, 64'd0);
        tick();
        expect_state("post_rst", 64'd4, 64'd0, 1'b1, 32'd1);

        vecs[0]  = '{0, 0, 0, 64'd0};
        vecs[1]  = '{1, 1, 0, 64'd0};
        vecs[2]  = '{0, 1, 0, 64'd0};
        vecs[3]  = '{1, 0, 0, 64'd0};
        vecs[4]  = '{1, 0, 1, 64'h100};
        vecs[5]  = '{0, 0, 0, 64'd0};
        vecs[6]  = '{0, 1, 1, 64'h200};
        vecs[7]  = '{0, 0, 0, 64'd0};
        vecs[8]  = '{0, 0, 0, 64'd0};
        vecs[9]  = '{1, 1, 1, 64'h10};
        vecs[10] = '{0, 0, 0, 64'd0};
        vecs[11] = '{0, 0, 0, 64'd0};
        foreach (vecs[i]) begin
            set_in(vecs[i].s, vecs[i].f, vecs[i].r, vecs[i].t);
            tick();
        end
        set_in(0, 0, 0, 64'd0);
        tick();

`ifndef FETCH_BOUNDS_CHECK_EN
        set_in(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        set_in(0, 0, 0, 64'd0);
        tick();
        check("wrap_pc",    imem_bus.imem_addr, 64'd0);
        check("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        set_in(0, 0, 1, 64'h3FE);
        tick();
        set_in(0, 0, 0, 64'd0);
        tick();
        check("nochk_pc",    imem_bus.imem_addr, 64'h402);
        check("nochk_fault", 64'(fault), 64'd0);
`else
        for (int j = 0; j < 2; j++) begin
            set_in(0, 0, 1, (j == 0) ? 64'h3FE : 64'h400);
            tick();
            set_in(0, 0, 0, 64'd0);
            check("flt_set",   64'(fault), 64'd1);
            check("flt_valid", 64'(if_valid), 64'd0);
            for (int k = 0; k < 2; k++) begin
                tick();
                check("flt_hold_pc", imem_bus.imem_addr, (j == 0) ? 64'h3FE : 64'h400);
                check("flt_hold_v",  64'(if_valid), 64'd0);
                check("flt_hold_f",  64'(fault), 64'd1);
            end
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("flt_clr",    64'(fault), 64'd0);
            check("flt_clr_pc", imem_bus.imem_addr, 64'd0);
        end
        set_in(0, 0, 1, 64'h3F8);
        tick();
        set_in(0, 0, 0, 64'd0);
        tick();
        check("seq_ok", 64'(fault), 64'd0);
        tick();
        check("seq_flt",    64'(fault), 64'd1);
        check("seq_if_pc",  if_pc, 64'h3FC);
        check("seq_pc",     imem_bus.imem_addr, 64'h400);
        tick();
        check("seq_bubble", 64'(if_valid), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
